// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences WB-stage TLB management ops (search/read/write/fill/invalidate)
// onto the TLB, owns the fill index counter and shares search port 1 with EX lookups.
module tlb_op_ctrl #(
    parameter int              TLBNUM    = 16,
    parameter int              IDXW      = $clog2(TLBNUM),
    parameter logic [IDXW-1:0] FILL_SEED = IDXW'(14)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic [4:0]      op_inv_op,
    input  logic [9:0]      op_asid,
    input  logic [18:0]     op_vppn,
    input  logic [IDXW-1:0] op_index,
    output logic            done_valid,
    input  logic            done_ready,
    output logic            done_found,
    output logic [IDXW-1:0] done_index,
    output logic            done_err,
    input  logic            mem_req,
    input  logic [18:0]     mem_vppn,
    input  logic [9:0]      mem_asid,
    output logic            mem_gnt,
    output logic [18:0]     tlb_s1_vppn,
    output logic [9:0]      tlb_s1_asid,
    input  logic            tlb_s1_found,
    input  logic [IDXW-1:0] tlb_s1_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [IDXW-1:0] tlb_r_index,
    output logic            tlb_inv_valid,
    output logic [4:0]      tlb_inv_op
);

    typedef enum logic [2:0] {S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_DONE} state_t;

    localparam logic [2:0] OP_SRCH = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_WR   = 3'd3;
    localparam logic [2:0] OP_FILL = 3'd4;
    localparam logic [2:0] OP_INV  = 3'd5;

    state_t          state;
    logic [9:0]      asid_q;
    logic [18:0]     vppn_q;
    logic [IDXW-1:0] index_q;
    logic [IDXW-1:0] fill_cnt;
    logic            fill_sel;
    logic            own_s1;

    // Port 1 belongs to the controller only while a search or invalidate executes.
    assign own_s1      = (state == S_SRCH) || (state == S_INV);
    assign mem_gnt     = mem_req & ~own_s1;
    assign tlb_s1_vppn = own_s1 ? vppn_q : mem_vppn;
    assign tlb_s1_asid = own_s1 ? asid_q : mem_asid;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            op_ready      <= 1'b1;
            done_valid    <= 1'b0;
            done_found    <= 1'b0;
            done_index    <= '0;
            done_err      <= 1'b0;
            tlb_we        <= 1'b0;
            tlb_w_index   <= '0;
            tlb_r_index   <= '0;
            tlb_inv_valid <= 1'b0;
            tlb_inv_op    <= '0;
            asid_q        <= '0;
            vppn_q        <= '0;
            index_q       <= '0;
            fill_sel      <= 1'b0;
            fill_cnt      <= FILL_SEED;
        end else begin
            tlb_we        <= 1'b0;
            tlb_inv_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        asid_q     <= op_asid;
                        vppn_q     <= op_vppn;
                        index_q    <= op_index;
                        fill_sel   <= 1'b0;
                        done_found <= 1'b0;
                        done_err   <= 1'b0;
                        op_ready   <= 1'b0;
                        case (op_code)
                            OP_SRCH: state <= S_SRCH;
                            OP_RD: begin
                                state       <= S_RD;
                                tlb_r_index <= op_index;
                            end
                            OP_WR: begin
                                state       <= S_WR;
                                tlb_we      <= 1'b1;
                                tlb_w_index <= op_index;
                            end
                            OP_FILL: begin
                                state       <= S_WR;
                                fill_sel    <= 1'b1;
                                tlb_we      <= 1'b1;
                                tlb_w_index <= fill_cnt;
                            end
                            OP_INV: begin
                                if (op_inv_op > 5'd6) begin
                                    state      <= S_DONE;
                                    done_valid <= 1'b1;
                                    done_err   <= 1'b1;
                                    done_index <= '0;
                                end else begin
                                    state         <= S_INV;
                                    tlb_inv_valid <= 1'b1;
                                    tlb_inv_op    <= op_inv_op;
                                end
                            end
                            default: begin
                                state      <= S_DONE;
                                done_valid <= 1'b1;
                                done_err   <= 1'b1;
                                done_index <= '0;
                            end
                        endcase
                    end
                end
                S_SRCH: begin
                    done_found <= tlb_s1_found;
                    done_index <= tlb_s1_found ? tlb_s1_index : '0;
                    done_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_RD: begin
                    done_index <= index_q;
                    done_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_WR: begin
                    done_index  <= tlb_w_index;
                    tlb_w_index <= '0;
                    if (fill_sel) fill_cnt <= fill_cnt + IDXW'(1);
                    done_valid  <= 1'b1;
                    state       <= S_DONE;
                end
                S_INV: begin
                    done_index <= '0;
                    tlb_inv_op <= '0;
                    done_valid <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    // Read index stays driven through DONE so TLB read data is valid with the result.
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        op_ready    <= 1'b1;
                        tlb_r_index <= '0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
